// File: rtl/divider_iter_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and iteration count.
package divider_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    localparam int         ITER_COUNT = 32;
    localparam logic [5:0] ITER_LAST  = 6'(ITER_COUNT - 1);

endpackage

// File: rtl/divider_iter_div_step.sv
// One restoring shift-subtract step: trial-subtract the divisor from the shifted remainder.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] diff;

    // rem_in carries one extra MSB because the shifted remainder can reach 2*divisor-1.
    always_comb begin
        diff    = rem_in - {1'b0, divisor};
        q_bit   = (rem_in >= {1'b0, divisor});
        rem_out = q_bit ? diff[WIDTH-1:0] : rem_in[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_iter.sv
// Iterative 32-cycle restoring divider (DIV/DIVU) producing quotient (LO) and remainder (HI).
module divider_iter
    import divider_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    div_state_t         state, state_nxt;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH-1:0]   dvd_raw;
    logic               q_neg;
    logic               r_neg;
    logic               dz;

    logic [WIDTH-1:0]   rem_nxt;
    logic               q_bit;
    logic [WIDTH-1:0]   quo_nxt;
    logic               last_step;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
        logic signed [WIDTH-1:0] xs;
        xs = x;
        return (is_signed && xs < 0) ? WIDTH'(-xs) : x;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x, input logic neg);
        logic signed [WIDTH-1:0] xs;
        xs = x;
        return neg ? WIDTH'(-xs) : x;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}),
        .divisor (dvs_mag),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    assign quo_nxt   = {acc[WIDTH-2:0], q_bit};
    assign last_step = (cnt == ITER_LAST);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operands are held as magnitudes; the sign fix-up is applied only on the final step.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            dvs_mag  <= '0;
            dvd_raw  <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            dz       <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cnt     <= '0;
                        acc     <= {{WIDTH{1'b0}}, magnitude(dividend, sign)};
                        dvs_mag <= magnitude(divisor, sign);
                        dvd_raw <= dividend;
                        q_neg   <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg   <= sign & dividend[WIDTH-1];
                        dz      <= (divisor == '0);
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 6'd1;
                    acc <= {rem_nxt, quo_nxt};
                    if (last_step) begin
                        q        <= dz ? {WIDTH{1'b1}} : apply_sign(quo_nxt, q_neg);
                        r        <= dz ? dvd_raw : apply_sign(rem_nxt, r_neg);
                        div_zero <= dz;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter: directed corner cases plus random operands vs a reference model.
module tb_divider_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;
    logic [31:0] prev_q = 0;
    logic [31:0] prev_r = 0;

    divider_iter #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sign     (sign),
        .dividend (dividend),
        .divisor  (divisor),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic (truncating), so -2^31 / -1 cannot overflow.
    function automatic logic [64:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qq, rr;
        if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, qq[31:0], rr[31:0]};
    endfunction

    // Call at a point after a rising edge; start is accepted on the next falling edge (E0).
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input bit disturb);
        logic [64:0] exp;
        int n;
        bit got;
        exp      = model(s, a, b);
        start    = 1'b1;
        sign     = s;
        dividend = a;
        divisor  = b;
        @(negedge clk); #1;
        start = 1'b0;
        n   = 0;
        got = 0;
        while (n < 100 && !got) begin
            @(posedge clk);
            if (done) got = 1;
            else begin
                if (n == 16) begin
                    chk("busy_mid_run", {31'd0, busy}, 32'd1);
                    chk("q_hold_run", q, prev_q);
                    chk("r_hold_run", r, prev_r);
                end
                if (disturb && n == 4) begin
                    start    = 1'b1;
                    sign     = ~s;
                    dividend = $urandom;
                    divisor  = $urandom;
                end
                @(negedge clk); #1;
                start = 1'b0;
                n++;
            end
        end
        chk("done_latency", n, 32);
        chk("busy_with_done", {31'd0, busy}, 32'd0);
        chk("q", q, exp[63:32]);
        chk("r", r, exp[31:0]);
        chk("div_zero", {31'd0, div_zero}, {31'd0, exp[64]});
        prev_q = exp[63:32];
        prev_r = exp[31:0];
    endtask

    task automatic idle_check();
        @(posedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_not_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int saw;
        rst      = 1'b1;
        start    = 1'b0;
        sign     = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #1;
        chk("rst_q", q, 32'd0);
        chk("rst_r", r, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        repeat (2) @(posedge clk);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 1'b0);        idle_check();
        run_div(1'b1, -32'sd7, 32'd2, 1'b0);        idle_check();
        run_div(1'b1, 32'd7, -32'sd2, 1'b0);        idle_check();
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); idle_check();
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);  idle_check();
        run_div(1'b0, 32'd5, 32'd0, 1'b0);          idle_check();
        run_div(1'b1, -32'sd5, 32'd0, 1'b0);        idle_check();
        run_div(1'b0, 32'd1000, 32'd33, 1'b1);      idle_check();

        // Back-to-back: next start accepted while in DONE.
        run_div(1'b1, 32'd12345, -32'sd17, 1'b0);
        run_div(1'b0, 32'hDEAD_BEEF, 32'h0001_0000, 1'b0);
        idle_check();

        // Reset mid-operation at iteration 10.
        start    = 1'b1;
        sign     = 1'b0;
        dividend = 32'd777;
        divisor  = 32'd5;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_q", q, 32'd0);
        chk("midrst_r", r, 32'd0);
        @(posedge clk);
        rst = 1'b0;
        saw = 0;
        repeat (40) begin
            @(posedge clk);
            if (done || busy) saw++;
        end
        chk("midrst_no_done", saw, 0);
        prev_q = 32'd0;
        prev_r = 32'd0;
        run_div(1'b0, 32'd9, 32'd3, 1'b0);          idle_check();

        for (int i = 0; i < 24; i++) begin
            logic        s;
            logic [31:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(1, 20));
                1: b = (i % 8 == 3) ? 32'd0 : $urandom;
                2: b = 32'(-$signed(32'($urandom_range(1, 300))));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_div(s, a, b, (i % 7 == 5));
            if (i % 3 != 0) idle_check();
        end
        idle_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_iter.md
DIVIDER_ITER -- requirements
Module: divider_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates occur on the falling edge of clk.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a division; sampled on the falling edge.
REQ-005 SHALL have port sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start.
REQ-006 SHALL have port dividend  input  32  numerator; captured with start.
REQ-007 SHALL have port divisor  input  32  denominator; captured with start.
REQ-008 SHALL have port q  output  32  quotient, destined for the LO register.
REQ-009 SHALL have port r  output  32  remainder, destined for the HI register.
REQ-010 SHALL have port busy  output  1  division in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse; q/r valid, used as the HI/LO register write enable.
REQ-012 SHALL have port div_zero  output  1  the last completed operation had divisor == 0.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE or DONE: operands and sign are captured, the iteration count clears, and the FSM moves to RUN (edge E0).
REQ-015 SHALL ignore start while in RUN; the captured operands are not disturbed.
REQ-016 SHALL perform one restoring shift-subtract step per falling edge in RUN, 32 steps in total (edges E1..E32).
REQ-017 SHALL load q, r and div_zero at E32 and enter DONE.
REQ-018 SHALL hold done high for exactly the cycle after E32, then return to IDLE at E33 unless start is accepted at E33.
REQ-019 SHALL drive busy high from E0 through E32 and low otherwise; done and busy are never high together.
REQ-020 SHALL, in signed mode, divide operand magnitudes, negate q when the operand signs differ, and give r the sign of the dividend (truncation toward zero).
REQ-021 SHALL treat operands as plain unsigned 32-bit values in unsigned mode.
REQ-022 SHALL produce q = 32'h80000000, r = 0 for signed 32'h80000000 / 32'hFFFFFFFF, with no exception.
REQ-023 SHALL produce q = 32'hFFFFFFFF, r = dividend and div_zero = 1 for divisor == 0, with the same 33-edge latency.
REQ-024 SHALL hold q, r and div_zero stable from E32 until the next completion; they do not change during a subsequent RUN.
REQ-025 SHALL, on reset mid-operation, abandon the computation and return to IDLE; no done pulse follows.

Reset
REQ-026 SHALL, while rst is high and independent of clk, drive state = IDLE, q = 0, r = 0, busy = 0, done = 0, div_zero = 0, and clear all internal registers.
REQ-027 SHALL accept start on the first falling edge after rst deasserts.

Structure
REQ-028 SHALL take the FSM state encodings and the iteration-count constant (32) from the shared CPU package.
REQ-029 SHALL place one step in sub-module div_step: combinational; inputs partial remainder and divisor; outputs the next partial remainder and the quotient bit.
REQ-030 SHALL use a 6-bit iteration counter and a 64-bit remainder/quotient shift register, with no multiplier.

Verification
REQ-031 SHALL cover unsigned 100 / 7 -> q = 14, r = 2, done exactly 33 falling edges after start acceptance.
REQ-032 SHALL cover signed -7 / 2 -> q = 32'hFFFFFFFD, r = 32'hFFFFFFFF; signed 7 / -2 -> q = 32'hFFFFFFFD, r = 1.
REQ-033 SHALL cover signed 32'h80000000 / 32'hFFFFFFFF -> q = 32'h80000000, r = 0; unsigned 32'hFFFFFFFF / 1 -> q = 32'hFFFFFFFF, r = 0.
REQ-034 SHALL cover 5 / 0 (either mode) -> q = 32'hFFFFFFFF, r = 5, div_zero = 1, done at E32.
REQ-035 SHALL cover start pulsed again at E5 with new operands -> ignored, the original result is delivered.
REQ-036 SHALL cover rst asserted at iteration 10 -> busy = 0, q = r = 0, no done; then 9 / 3 -> q = 3, r = 0.
